// File: rtl/pcie_rst_seq.sv
// pcie_rst_seq: holds the PCIe core in reset, releases it, then staggers the application resets.
// Optional simulation hold shortcut is compiled in only when PCIE_RST_SEQ_SIM_SHORTCUT_EN is defined.
module pcie_rst_seq #(
    parameter int         NUM_APP        = 4,
    parameter int         CNT_W          = 11,
    parameter int         HOLD_CYCLES    = 1024,
    parameter int         STAGGER        = 16,
    parameter int         SIM_HOLD       = 32,
    parameter logic [4:0] LTSSM_RST_CODE = 5'h10
) (
    input  logic               pld_clk,
    input  logic               any_rstn_rr,
    input  logic               dlup_exit,
    input  logic               hotrst_exit,
    input  logic               l2_exit,
    input  logic [4:0]         ltssm,
    input  logic               test_sim,
    output logic               srst,
    output logic               crst,
    output logic [NUM_APP-1:0] app_rstn,
    output logic [2:0]         seq_state,
    output logic [3:0]         rst_cause,
    output logic [7:0]         exit_cnt
);

    localparam int IDX_W = (NUM_APP > 1) ? $clog2(NUM_APP) : 1;

    typedef enum logic [2:0] {
        ST_HOLD     = 3'd0,
        ST_REL_CORE = 3'd1,
        ST_REL_APP  = 3'd2,
        ST_RUN      = 3'd3
    } state_t;

    logic               r_dlup_exit;
    logic               r_hotrst_exit;
    logic               r_l2_exit;
    logic [4:0]         r_ltssm;
    logic [3:0]         w_cause;
    logic               r_exit_evt;
    logic [3:0]         r_exit_cause;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_hold_last;
    logic [CNT_W-1:0]   w_stag_last;
    logic [IDX_W-1:0]   r_app_idx;
    logic [IDX_W-1:0]   w_idx_nxt;

    logic [3:0]         r_last_cause;
    logic [7:0]         r_evt_cnt;
    logic [NUM_APP-1:0] w_app_rel;

    logic               r_srst;
    logic               r_crst;
    logic [NUM_APP-1:0] r_app_rstn;
    logic [2:0]         r_seq_state;
    logic [3:0]         r_rst_cause;
    logic [7:0]         r_exit_cnt;

`ifdef PCIE_RST_SEQ_SIM_SHORTCUT_EN
    // test_sim is only consulted at the HOLD terminal compare, i.e. sampled while in HOLD.
    assign w_hold_last = test_sim ? CNT_W'(SIM_HOLD - 1) : CNT_W'(HOLD_CYCLES - 1);
`else
    logic w_unused_test_sim;
    assign w_unused_test_sim = test_sim;
    assign w_hold_last       = CNT_W'(HOLD_CYCLES - 1);
`endif

    assign w_stag_last = CNT_W'(STAGGER - 1);

    // Cause bits: bit0 dlup, bit1 hotrst, bit2 l2, bit3 ltssm reset code.
    assign w_cause = {(r_ltssm == LTSSM_RST_CODE), ~r_l2_exit, ~r_hotrst_exit, ~r_dlup_exit};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge pld_clk or negedge any_rstn_rr) begin
        if (!any_rstn_rr) begin
            r_dlup_exit   <= 1'b1;
            r_hotrst_exit <= 1'b1;
            r_l2_exit     <= 1'b1;
            r_ltssm       <= 5'd0;
            r_exit_evt    <= 1'b0;
            r_exit_cause  <= 4'd0;
        end else begin
            r_dlup_exit   <= dlup_exit;
            r_hotrst_exit <= hotrst_exit;
            r_l2_exit     <= l2_exit;
            r_ltssm       <= ltssm;
            r_exit_evt    <= |w_cause;
            r_exit_cause  <= w_cause;
        end
    end

    always_ff @(posedge pld_clk or negedge any_rstn_rr) begin
        if (!any_rstn_rr) begin
            r_state   <= ST_HOLD;
            r_cnt     <= '0;
            r_app_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_app_idx <= w_idx_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_app_idx;
        if (r_exit_evt) begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (r_cnt == w_hold_last) begin
                        w_state_nxt = ST_REL_CORE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                ST_REL_CORE: begin
                    w_state_nxt = ST_REL_APP;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
                ST_REL_APP: begin
                    if (r_app_idx == IDX_W'(NUM_APP - 1)) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == w_stag_last) begin
                        w_idx_nxt = r_app_idx + IDX_W'(1);
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    w_state_nxt = ST_RUN;
                end
                default: begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    // Bit i is released once the stagger index has reached it; all bits stay released in RUN.
    always_comb begin
        w_app_rel = '0;
        for (int i = 0; i < NUM_APP; i++) begin
            w_app_rel[i] = (r_state == ST_RUN) ||
                           ((r_state == ST_REL_APP) && (IDX_W'(i) <= r_app_idx));
        end
    end

    always_ff @(posedge pld_clk or negedge any_rstn_rr) begin
        if (!any_rstn_rr) begin
            r_last_cause <= 4'd0;
            r_evt_cnt    <= 8'd0;
        end else if (r_exit_evt) begin
            r_last_cause <= r_exit_cause;
            if (r_evt_cnt != 8'hFF) begin
                r_evt_cnt <= r_evt_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge pld_clk or negedge any_rstn_rr) begin
        if (!any_rstn_rr) begin
            r_srst      <= 1'b1;
            r_crst      <= 1'b1;
            r_app_rstn  <= '0;
            r_seq_state <= ST_HOLD;
            r_rst_cause <= 4'd0;
            r_exit_cnt  <= 8'd0;
        end else begin
            r_srst      <= (r_state == ST_HOLD);
            r_crst      <= (r_state == ST_HOLD);
            r_app_rstn  <= w_app_rel;
            r_seq_state <= r_state;
            r_rst_cause <= r_last_cause;
            r_exit_cnt  <= r_evt_cnt;
        end
    end

    assign srst      = r_srst;
    assign crst      = r_crst;
    assign app_rstn  = r_app_rstn;
    assign seq_state = r_seq_state;
    assign rst_cause = r_rst_cause;
    assign exit_cnt  = r_exit_cnt;

endmodule

// File: tb/tb_pcie_rst_seq.sv
// Bench for pcie_rst_seq: timeline model (cycles since last restart) checked every cycle plus directed literal checks.
module tb_pcie_rst_seq;

    localparam int NUM_APP = 4;
    localparam int STAGGER = 16;
`ifdef PCIE_RST_SEQ_SIM_SHORTCUT_EN
    localparam int EXP_H = 32;
`else
    localparam int EXP_H = 1024;
`endif
    localparam int MAXC = 16384;

    logic               pld_clk     = 1'b0;
    logic               any_rstn_rr = 1'b0;
    logic               dlup_exit   = 1'b1;
    logic               hotrst_exit = 1'b1;
    logic               l2_exit     = 1'b1;
    logic [4:0]         ltssm       = 5'd0;
    logic               test_sim    = 1'b1;
    logic               srst;
    logic               crst;
    logic [NUM_APP-1:0] app_rstn;
    logic [2:0]         seq_state;
    logic [3:0]         rst_cause;
    logic [7:0]         exit_cnt;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc   = 0;
    logic [3:0] cause_hist [0:MAXC-1];
    logic [20:0] exp_vec = '0;

    pcie_rst_seq u_dut (
        .pld_clk     (pld_clk),
        .any_rstn_rr (any_rstn_rr),
        .dlup_exit   (dlup_exit),
        .hotrst_exit (hotrst_exit),
        .l2_exit     (l2_exit),
        .ltssm       (ltssm),
        .test_sim    (test_sim),
        .srst        (srst),
        .crst        (crst),
        .app_rstn    (app_rstn),
        .seq_state   (seq_state),
        .rst_cause   (rst_cause),
        .exit_cnt    (exit_cnt)
    );

    always #5 pld_clk = ~pld_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Edge counter since reset release, and the cause vector sampled at each edge.
    always @(posedge pld_clk or negedge any_rstn_rr) begin
        if (!any_rstn_rr) begin
            cyc <= 0;
        end else begin
            cyc <= cyc + 1;
            if (cyc + 1 < MAXC)
                cause_hist[cyc+1] <= {ltssm == 5'h10, ~l2_exit, ~hotrst_exit, ~dlup_exit};
        end
    end

    // Model: an exit sampled at edge k restarts the sequence at edge k+2 and shows up
    // at the outputs after edge k+3; outputs at edge n follow d = n-1-(last restart).
    initial begin : compare
        int s;
        int ecnt;
        int n;
        int d;
        logic [3:0] lcause;
        logic       e_srst;
        logic [NUM_APP-1:0] e_app;
        logic [2:0] e_seq;
        s = 0; ecnt = 0; lcause = 4'd0;
        forever begin
            @(negedge pld_clk);
            if (!any_rstn_rr) begin
                s = 0; ecnt = 0; lcause = 4'd0; n = 0;
            end else begin
                n = cyc;
                if (n - 3 >= 1 && cause_hist[n-3] != 4'd0) begin
                    s      = n - 1;
                    lcause = cause_hist[n-3];
                    ecnt   = (ecnt < 255) ? ecnt + 1 : 255;
                end
            end
            d = n - 1 - s;
            e_srst = (d < EXP_H);
            for (int i = 0; i < NUM_APP; i++)
                e_app[i] = (d >= EXP_H + 1 + i * STAGGER);
            if (d < EXP_H)                                  e_seq = 3'd0;
            else if (d == EXP_H)                            e_seq = 3'd1;
            else if (d <= EXP_H + 1 + (NUM_APP-1)*STAGGER)  e_seq = 3'd2;
            else                                            e_seq = 3'd3;
            exp_vec = {e_srst, e_srst, e_app, e_seq, lcause, 8'(ecnt)};
            check("cycle outputs", {11'd0, srst, crst, app_rstn, seq_state, rst_cause, exit_cnt},
                  {11'd0, exp_vec});
        end
    end

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    endtask

    task automatic goto(input int n);
        int guard = 0;
        while (cyc != n && guard < 20000) begin
            @(negedge pld_clk);
            guard++;
        end
        if (cyc != n) begin
            n_err++;
            $display("FAIL timeout waiting for cycle %0d: got %0d", n, cyc);
            finish_run();
        end
    endtask

    task automatic at(input int n);
        goto(n);
        #1;
    endtask

    initial begin : stim
        int s;
        int k;
        int n0;
        repeat (3) @(negedge pld_clk);
        #1 any_rstn_rr = 1'b1;

        // Power-on sequence, restart at edge 0.
        at(EXP_H);
        check("A srst held", srst, 1);
        check("A model srst held", exp_vec[20], 1);
        at(EXP_H + 1);
        check("A srst release", srst, 0);
        check("A crst release", crst, 0);
        check("A app still held", app_rstn, 4'h0);
        check("A seq REL_CORE", seq_state, 1);
        check("A model srst release", exp_vec[20], 0);
        at(EXP_H + 2);
        check("A app0", app_rstn, 4'h1);
        at(EXP_H + 2 + STAGGER - 1);
        check("A app0 only", app_rstn, 4'h1);
        at(EXP_H + 2 + STAGGER);
        check("A app1", app_rstn, 4'h3);
        at(EXP_H + 2 + 3*STAGGER);
        check("A app3", app_rstn, 4'hF);
        check("A seq REL_APP", seq_state, 2);
        at(EXP_H + 3 + 3*STAGGER);
        check("A seq RUN", seq_state, 3);
        check("A model seq RUN", exp_vec[14:12], 3);

        // Hot reset pulse in RUN.
        goto(EXP_H + 3 + 3*STAGGER + 20);
        hotrst_exit = 1'b0;
        k = cyc + 1;
        @(negedge pld_clk);
        hotrst_exit = 1'b1;
        at(k + 2);
        check("B not yet", srst, 0);
        at(k + 3);
        check("B srst", srst, 1);
        check("B crst", crst, 1);
        check("B app", app_rstn, 4'h0);
        check("B seq", seq_state, 0);
        check("B cause", rst_cause, 4'b0010);
        check("B cnt", exit_cnt, 1);
        s = k + 2;
        at(s + EXP_H);
        check("B srst held", srst, 1);
        at(s + EXP_H + 1);
        check("B srst release", srst, 0);

        // ltssm reset code for 5 cycles after app_rstn[1] release.
        at(s + EXP_H + 2 + STAGGER);
        check("C app1 released", app_rstn, 4'h3);
        n0 = cyc;
        ltssm = 5'h10;
        at(n0 + 3);
        check("C app before", app_rstn, 4'h3);
        at(n0 + 4);
        check("C app reset", app_rstn, 4'h0);
        check("C srst reset", srst, 1);
        goto(n0 + 5);
        ltssm = 5'd0;
        at(n0 + 8);
        check("C cnt", exit_cnt, 6);
        check("C cause", rst_cause, 4'b1000);
        s = n0 + 7;
        at(s + EXP_H);
        check("C srst held", srst, 1);
        at(s + EXP_H + 1);
        check("C srst release", srst, 0);

        // Exit on the HOLD terminal-count cycle.
        goto(s + EXP_H + 3 + 3*STAGGER + 10);
        hotrst_exit = 1'b0;
        k = cyc + 1;
        @(negedge pld_clk);
        hotrst_exit = 1'b1;
        s = k + 2;
        at(k + 3);
        check("D cnt pulse", exit_cnt, 7);
        goto(s + EXP_H - 3);
        dlup_exit = 1'b0;
        l2_exit   = 1'b0;
        @(negedge pld_clk);
        dlup_exit = 1'b1;
        l2_exit   = 1'b1;
        at(s + EXP_H + 1);
        check("D seq stays HOLD", seq_state, 0);
        check("D srst stays", srst, 1);
        check("D cause", rst_cause, 4'b0101);
        check("D cnt", exit_cnt, 8);
        s = s + EXP_H;
        at(s + EXP_H);
        check("D srst held", srst, 1);
        at(s + EXP_H + 1);
        check("D srst release", srst, 0);
        check("D seq REL_CORE", seq_state, 1);

        // 300 sustained exit cycles saturate the counter.
        goto(s + EXP_H + 5);
        dlup_exit = 1'b0;
        n0 = cyc;
        goto(n0 + 300);
        dlup_exit = 1'b1;
        at(n0 + 303);
        check("E cnt saturated", exit_cnt, 255);
        check("E cause", rst_cause, 4'b0001);
        s = n0 + 302;

        // Asynchronous reset in REL_APP.
        at(s + EXP_H + 2 + STAGGER + 3);
        check("E app before reset", app_rstn, 4'h3);
        check("E seq before reset", seq_state, 2);
        #1 any_rstn_rr = 1'b0;
        #1;
        check("E rst srst", srst, 1);
        check("E rst crst", crst, 1);
        check("E rst app", app_rstn, 4'h0);
        check("E rst seq", seq_state, 0);
        check("E rst cause", rst_cause, 4'h0);
        check("E rst cnt", exit_cnt, 0);
        repeat (3) @(negedge pld_clk);
        #1 any_rstn_rr = 1'b1;
        at(1);
        check("E restart seq", seq_state, 0);
        check("E restart srst", srst, 1);
        at(EXP_H);
        check("E restart srst held", srst, 1);
        at(EXP_H + 1);
        check("E restart srst release", srst, 0);
        at(EXP_H + 5);
        finish_run();
    end

endmodule
